match_sequencer: RTL and testbench

//  Match-level controller that sequences the pong datapath: attract/serve/play/point/game-over.

---
 rtl/match_sequencer_pkg.sv | 20 ++
 rtl/match_sequencer_tick.sv | 32 +++
 rtl/match_sequencer.sv | 173 +++++++++++++++++
 tb/tb_match_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/match_sequencer_pkg.sv
// Shared constants for the pong match sequencer: FSM state encodings and default
// timing/win parameters, plus a small constant helper.
package match_sequencer_pkg;

    localparam logic [2:0] MS_IDLE  = 3'd0;
    localparam logic [2:0] MS_SERVE = 3'd1;
    localparam logic [2:0] MS_PLAY  = 3'd2;
    localparam logic [2:0] MS_POINT = 3'd3;
    localparam logic [2:0] MS_OVER  = 3'd4;

    localparam int DEF_TICK_DIV    = 131072;
    localparam int DEF_SERVE_TICKS = 64;
    localparam int DEF_POINT_TICKS = 96;
    localparam int DEF_WIN_SCORE   = 9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/match_sequencer_tick.sv
// Free-running clock divider: counts 0..DIV-1 and flags the last count as a one-cycle tick.
module tick_divider
    import match_sequencer_pkg::*;
#(
    parameter int DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller for pong: sequences attract/serve/play/point/game-over, paces the
// ball/pad engine with slowed tick enables and keeps both scores.
module match_sequencer
    import match_sequencer_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SERVE_TICKS = DEF_SERVE_TICKS,
    parameter int POINT_TICKS = DEF_POINT_TICKS,
    parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       pad_tick,
    output logic       game_tick,
    output logic       ball_restart,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner
);

    localparam int            DW         = $clog2(max_int(SERVE_TICKS, POINT_TICKS) + 1);
    localparam logic [DW-1:0] SERVE_LAST = DW'(SERVE_TICKS - 1);
    localparam logic [DW-1:0] POINT_LAST = DW'(POINT_TICKS - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    logic          tick;
    logic          start_edge;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [3:0]    score_left_q, score_left_d;
    logic [3:0]    score_right_q, score_right_d;
    logic          start_q, start_d;
    logic          pad_tick_q, pad_tick_d;
    logic          game_tick_q, game_tick_d;
    logic          ball_restart_q, ball_restart_d;
    logic          serve_dir_q, serve_dir_d;
    logic          game_over_q, game_over_d;
    logic          winner_q, winner_d;

    tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        start_edge     = start & ~start_q;
        start_d        = start;
        state_d        = state_q;
        dly_d          = dly_q;
        score_left_d   = score_left_q;
        score_right_d  = score_right_q;
        serve_dir_d    = serve_dir_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        ball_restart_d = 1'b0;
        // Tick enables look at the state before any transition taken this cycle.
        pad_tick_d     = tick & ((state_q == MS_SERVE) | (state_q == MS_PLAY));
        game_tick_d    = tick & (state_q == MS_PLAY);

        case (state_q)
            MS_IDLE: begin
                if (start_edge) begin
                    state_d        = MS_SERVE;
                    dly_d          = '0;
                    score_left_d   = 4'd0;
                    score_right_d  = 4'd0;
                    serve_dir_d    = 1'b0;
                    ball_restart_d = 1'b1;
                end
            end
            MS_SERVE: begin
                if (tick) begin
                    if (dly_q == SERVE_LAST) begin
                        state_d = MS_PLAY;
                        dly_d   = '0;
                    end else begin
                        dly_d = dly_q + DW'(1);
                    end
                end
            end
            MS_PLAY: begin
                // A simultaneous double miss credits the right player only.
                if (miss_left) begin
                    score_right_d = score_right_q + 4'd1;
                    serve_dir_d   = 1'b0;
                    state_d       = MS_POINT;
                    dly_d         = '0;
                end else if (miss_right) begin
                    score_left_d = score_left_q + 4'd1;
                    serve_dir_d  = 1'b1;
                    state_d      = MS_POINT;
                    dly_d        = '0;
                end
            end
            MS_POINT: begin
                if (tick) begin
                    if (dly_q == POINT_LAST) begin
                        dly_d = '0;
                        if ((score_left_q == WIN) || (score_right_q == WIN)) begin
                            state_d     = MS_OVER;
                            winner_d    = (score_right_q == WIN);
                            game_over_d = 1'b1;
                        end else begin
                            state_d        = MS_SERVE;
                            ball_restart_d = 1'b1;
                        end
                    end else begin
                        dly_d = dly_q + DW'(1);
                    end
                end
            end
            MS_OVER: begin
                if (start_edge) begin
                    state_d        = MS_SERVE;
                    dly_d          = '0;
                    score_left_d   = 4'd0;
                    score_right_d  = 4'd0;
                    game_over_d    = 1'b0;
                    serve_dir_d    = ~winner_q;
                    ball_restart_d = 1'b1;
                end
            end
            default: begin
                state_d = MS_IDLE;
                dly_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= MS_IDLE;
            dly_q          <= '0;
            score_left_q   <= 4'd0;
            score_right_q  <= 4'd0;
            start_q        <= 1'b0;
            pad_tick_q     <= 1'b0;
            game_tick_q    <= 1'b0;
            ball_restart_q <= 1'b0;
            serve_dir_q    <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            dly_q          <= dly_d;
            score_left_q   <= score_left_d;
            score_right_q  <= score_right_d;
            start_q        <= start_d;
            pad_tick_q     <= pad_tick_d;
            game_tick_q    <= game_tick_d;
            ball_restart_q <= ball_restart_d;
            serve_dir_q    <= serve_dir_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
        end
    end

    assign pad_tick     = pad_tick_q;
    assign game_tick    = game_tick_q;
    assign ball_restart = ball_restart_q;
    assign serve_dir    = serve_dir_q;
    assign score_left   = score_left_q;
    assign score_right  = score_right_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer: a phase-level match model predicts every cycle's
// outputs into a queue; a monitor pops and compares one entry per clock.
module tb_match_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int SERVE_TICKS = 2;
    localparam int POINT_TICKS = 2;
    localparam int WIN_SCORE   = 3;
    localparam int W           = 14;

    logic       clk;
    logic       rst;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       pad_tick;
    logic       game_tick;
    logic       ball_restart;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       winner;

    match_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .SERVE_TICKS (SERVE_TICKS),
        .POINT_TICKS (POINT_TICKS),
        .WIN_SCORE   (WIN_SCORE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .miss_left    (miss_left),
        .miss_right   (miss_right),
        .pad_tick     (pad_tick),
        .game_tick    (game_tick),
        .ball_restart (ball_restart),
        .serve_dir    (serve_dir),
        .score_left   (score_left),
        .score_right  (score_right),
        .game_over    (game_over),
        .winner       (winner)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;
    bit           seen_over = 0;
    bit           start_r = 0;

    // behavioural match model
    typedef enum int {PH_IDLE, PH_SERVE, PH_PLAY, PH_POINT, PH_OVER} phase_t;
    phase_t m_phase = PH_IDLE;
    int     m_edges = 0;
    int     m_left  = 0;
    int     m_sl    = 0;
    int     m_sr    = 0;
    bit     m_dir   = 0;
    bit     m_over  = 0;
    bit     m_win   = 0;
    bit     m_prev_start = 0;

    task automatic model_edge(input logic r, input logic s, input logic ml, input logic mr);
        bit tk, sedge, pt, gt, br;
        pt = 0; gt = 0; br = 0;
        if (!r) begin
            m_phase = PH_IDLE; m_edges = 0; m_left = 0; m_sl = 0; m_sr = 0;
            m_dir = 0; m_over = 0; m_win = 0; m_prev_start = 0;
        end else begin
            m_edges++;
            tk    = ((m_edges % TICK_DIV) == 0);
            sedge = s && !m_prev_start;
            m_prev_start = s;
            pt = tk && (m_phase == PH_SERVE || m_phase == PH_PLAY);
            gt = tk && (m_phase == PH_PLAY);
            case (m_phase)
                PH_IDLE: if (sedge) begin
                    m_sl = 0; m_sr = 0; m_dir = 0; br = 1;
                    m_phase = PH_SERVE; m_left = SERVE_TICKS;
                end
                PH_SERVE: if (tk) begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_PLAY;
                end
                PH_PLAY: begin
                    if (ml) begin
                        m_sr++; m_dir = 0; m_phase = PH_POINT; m_left = POINT_TICKS;
                    end else if (mr) begin
                        m_sl++; m_dir = 1; m_phase = PH_POINT; m_left = POINT_TICKS;
                    end
                end
                PH_POINT: if (tk) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
                            m_phase = PH_OVER; m_over = 1; m_win = (m_sr == WIN_SCORE);
                        end else begin
                            m_phase = PH_SERVE; m_left = SERVE_TICKS; br = 1;
                        end
                    end
                end
                PH_OVER: if (sedge) begin
                    m_sl = 0; m_sr = 0; m_over = 0; m_dir = ~m_win; br = 1;
                    m_phase = PH_SERVE; m_left = SERVE_TICKS;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
        exp_q.push_back({pt, gt, br, m_dir, 4'(m_sl), 4'(m_sr), m_over, m_win});
    endtask

    // driver tasks
    task automatic drive(input logic r, input logic s, input logic ml, input logic mr);
        @(negedge clk);
        rst = r; start = s; miss_left = ml; miss_right = mr;
        model_edge(r, s, ml, mr);
    endtask

    task automatic rand_step(input bit allow_rst);
        logic r;
        if ($urandom_range(0, 15) == 0) start_r = ~start_r;
        r = allow_rst ? ($urandom_range(0, 799) != 0) : 1'b1;
        drive(r, start_r, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    endtask

    // monitor: one prediction per clock
    initial begin
        logic [W-1:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {pad_tick, game_tick, ball_restart, serve_dir, score_left, score_right,
                        game_over, winner};
                if (game_over) seen_over = 1;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs @%0t got pt=%b gt=%b br=%b dir=%b sl=%0d sr=%0d ov=%b win=%b want pt=%b gt=%b br=%b dir=%b sl=%0d sr=%0d ov=%b win=%b",
                             $time, got[13], got[12], got[11], got[10], got[9:6], got[5:2],
                             got[1], got[0], want[13], want[12], want[11], want[10],
                             want[9:6], want[5:2], want[1], want[0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        bit found;
        rst = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        repeat (3) drive(0, 0, 0, 0);

        // idle: misses must be ignored, nothing moves
        for (int i = 0; i < 20; i++)
            drive(1, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        // start edge then hold start high through serve into play
        start_r = 1;
        for (int i = 0; i < 40; i++) drive(1, 1, 0, 0);

        // simultaneous miss in play
        for (int i = 0; i < 100 && m_phase != PH_PLAY; i++) drive(1, 1, 0, 0);
        drive(1, 1, 1, 1);
        for (int i = 0; i < 30; i++) drive(1, 1, 0, 0);

        // randomized matches with occasional resets
        for (int i = 0; i < 4000; i++) rand_step(1);

        // reset landing mid-point on a tick cycle
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (m_phase == PH_POINT && ((m_edges + 1) % TICK_DIV) == 0) begin
                drive(0, start_r, 1, 1);
                found = 1;
            end else begin
                rand_step(0);
            end
        end
        for (int i = 0; i < 1000; i++) rand_step(1);
        drive(1, start_r, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
        total++;
        if (!seen_over) begin
            bad++;
            $display("FAIL reach_over got game_over_seen=%b want 1", seen_over);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
